// File: rtl/p2s_pkg.sv
// Shared framing definitions for the serial transmitter and receiver pair.
package p2s_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } p2s_state_t;

    localparam int   DATA_BITS   = 8;
    localparam int   FRAME_BITS  = 10;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic IDLE_LEVEL  = 1'b1;

endpackage

// File: rtl/p2s_bit_timer.sv
// Bit-time divider: emits a one-cycle tick on the last clock of every bit period.
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count clocks within the current bit; held at zero whenever no frame is running.
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/p2s.sv
// Parallel-to-serial transmitter: start bit, 8 data bits MSB first, stop bit.
module p2s
    import p2s_pkg::*;
#(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] parallelIn,
    input  logic       load,
    output logic       serialOut,
    output logic       busy,
    output logic       charSent
);

    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    p2s_state_t           state;
    p2s_state_t           state_next;
    logic [DATA_BITS-1:0] shift_reg;
    logic [DATA_BITS-1:0] shift_next;
    logic [2:0]           bit_cnt;
    logic [2:0]           bit_cnt_next;
    logic                 serial_next;
    logic                 busy_next;
    logic                 sent_next;
    logic                 tick;

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .enable(busy),
        .tick  (tick)
    );

    // State and registered outputs; reset aborts any frame without a completion pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            serialOut <= IDLE_LEVEL;
            busy      <= 1'b0;
            charSent  <= 1'b0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_cnt_next;
            serialOut <= serial_next;
            busy      <= busy_next;
            charSent  <= sent_next;
        end
    end

    // Next-state logic: the bit about to be driven is always shift_reg[7] before shifting.
    always_comb begin
        state_next   = state;
        shift_next   = shift_reg;
        bit_cnt_next = bit_cnt;
        serial_next  = serialOut;
        busy_next    = busy;
        sent_next    = 1'b0;
        case (state)
            IDLE: begin
                serial_next = IDLE_LEVEL;
                busy_next   = 1'b0;
                if (load) begin
                    state_next   = START;
                    shift_next   = parallelIn;
                    bit_cnt_next = '0;
                    serial_next  = START_LEVEL;
                    busy_next    = 1'b1;
                end
            end
            START: begin
                if (tick) begin
                    state_next   = DATA;
                    serial_next  = shift_reg[DATA_BITS-1];
                    bit_cnt_next = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        state_next   = STOP;
                        serial_next  = STOP_LEVEL;
                        bit_cnt_next = '0;
                    end else begin
                        shift_next   = {shift_reg[DATA_BITS-2:0], 1'b0};
                        serial_next  = shift_reg[DATA_BITS-2];
                        bit_cnt_next = bit_cnt + 3'd1;
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    state_next  = IDLE;
                    serial_next = IDLE_LEVEL;
                    busy_next   = 1'b0;
                    sent_next   = 1'b1;
                end
            end
            default: begin
                state_next  = IDLE;
                serial_next = IDLE_LEVEL;
                busy_next   = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_p2s.sv
// Self-checking bench: two transmitters (1 and 4 clocks per bit) against a frame-level model.
module tb_p2s;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_f, load_s;
    logic [7:0] pin_f, pin_s;
    logic       so_f, busy_f, sent_f;
    logic       so_s, busy_s, sent_s;

    int total = 0;
    int bad   = 0;

    int         bc[2] = '{1, 4};
    bit         act[2];
    int         elapsed[2];
    logic [9:0] frame[2];
    bit         pulse[2];

    logic [9:0] seen;
    int         cnt;

    p2s #(.BIT_CYCLES(1)) dut_fast (
        .clk       (clk),
        .reset     (rst),
        .parallelIn(pin_f),
        .load      (load_f),
        .serialOut (so_f),
        .busy      (busy_f),
        .charSent  (sent_f)
    );

    p2s #(.BIT_CYCLES(4)) dut_slow (
        .clk       (clk),
        .reset     (rst),
        .parallelIn(pin_s),
        .load      (load_s),
        .serialOut (so_s),
        .busy      (busy_s),
        .charSent  (sent_s)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    task automatic check_one(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Frame-level model: a frame is a 10-entry level list, each held bc cycles.
    task automatic model_edge(input int d, input logic ld, input logic [7:0] pin);
        if (rst) begin
            act[d]   = 1'b0;
            pulse[d] = 1'b0;
        end else if (act[d]) begin
            elapsed[d]++;
            pulse[d] = 1'b0;
            if (elapsed[d] == 10 * bc[d]) begin
                act[d]   = 1'b0;
                pulse[d] = 1'b1;
            end
        end else begin
            pulse[d] = 1'b0;
            if (ld) begin
                act[d]     = 1'b1;
                elapsed[d] = 0;
                frame[d][0] = 1'b0;
                for (int k = 1; k <= 8; k++) frame[d][k] = pin[8-k];
                frame[d][9] = 1'b1;
            end
        end
    endtask

    task automatic checkOutput();
        logic eo, eb, es;
        for (int d = 0; d < 2; d++) begin
            eo = act[d] ? frame[d][elapsed[d] / bc[d]] : 1'b1;
            eb = act[d];
            es = act[d] ? 1'b0 : pulse[d];
            if (d == 0) begin
                check_one("fast.serialOut", so_f, eo);
                check_one("fast.busy", busy_f, eb);
                check_one("fast.charSent", sent_f, es);
            end else begin
                check_one("slow.serialOut", so_s, eo);
                check_one("slow.busy", busy_s, eb);
                check_one("slow.charSent", sent_s, es);
            end
        end
    endtask

    // One clock: let the DUTs and the model see the same inputs, then compare away from the edge.
    task automatic applyStimulus();
        @(posedge clk);
        model_edge(0, load_f, pin_f);
        model_edge(1, load_s, pin_s);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; load_f = 1'b0; load_s = 1'b0; pin_f = 8'h00; pin_s = 8'h00;
        for (int i = 0; i < 2; i++) begin act[i] = 0; elapsed[i] = 0; frame[i] = '0; pulse[i] = 0; end
        #2;
        applyStimulus();
        applyStimulus();

        // A5 on the fast transmitter, 01 on the slow one, launched together.
        rst = 1'b0; load_f = 1'b1; pin_f = 8'hA5; load_s = 1'b1; pin_s = 8'h01;
        applyStimulus();
        seen = {9'b0, so_f};
        load_f = 1'b0; load_s = 1'b0; pin_f = 8'h00; pin_s = 8'hFE;
        for (int i = 0; i < 9; i++) begin
            applyStimulus();
            seen = {seen[8:0], so_f};
        end
        check_int("fast.A5_frame", int'(seen), int'(10'b0101001011));
        cnt = 0;
        for (int i = 0; i < 33; i++) begin
            applyStimulus();
            if (sent_f) cnt++;
        end
        check_int("fast.A5_pulses", cnt, 1);
        for (int i = 0; i < 4; i++) applyStimulus();

        // Second load during a frame is dropped; parallelIn changes do not leak in.
        load_f = 1'b1; pin_f = 8'hFF;
        applyStimulus();
        load_f = 1'b0;
        cnt = 0;
        applyStimulus();
        applyStimulus();
        load_f = 1'b1; pin_f = 8'h00;
        applyStimulus();
        load_f = 1'b0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (sent_f) cnt++;
        end
        check_int("fast.ignored_load_pulses", cnt, 1);

        // Back-to-back frames with load held high: one idle clock between them.
        load_f = 1'b1; pin_f = 8'h3C;
        applyStimulus();
        pin_f = 8'hC3;
        for (int i = 0; i < 21; i++) applyStimulus();
        load_f = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();

        // Reset mid-frame, then a full frame loaded on the first edge out of reset.
        load_f = 1'b1; pin_f = 8'h55; load_s = 1'b1; pin_s = 8'h55;
        applyStimulus();
        load_f = 1'b0; load_s = 1'b0;
        for (int i = 0; i < 4; i++) applyStimulus();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0; load_f = 1'b1; pin_f = 8'hAA; load_s = 1'b1; pin_s = 8'hAA;
        applyStimulus();
        load_f = 1'b0; load_s = 1'b0;
        for (int i = 0; i < 44; i++) applyStimulus();

        // Reset and load at the same edge: reset wins.
        rst = 1'b1; load_f = 1'b1; load_s = 1'b1; pin_f = 8'h81; pin_s = 8'h18;
        applyStimulus();
        rst = 1'b0; load_f = 1'b0; load_s = 1'b0;
        applyStimulus();
        applyStimulus();

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst    = ($urandom_range(0, 79) == 0);
            load_f = ($urandom_range(0, 3) == 0);
            load_s = ($urandom_range(0, 3) == 0);
            pin_f  = 8'($urandom);
            pin_s  = 8'($urandom);
            applyStimulus();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/p2s.md
P2S -- requirements
Module: p2s

Interface
REQ-001 Parameter BIT_CYCLES, default 1: clock cycles per serial bit; legal range 1..65535.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 parallelIn  input  8  character to transmit; sampled only when a load is accepted.
REQ-005 load  input  1  transmit request; level-sampled each rising edge.
REQ-006 serialOut  output  1  registered serial line; idle level 1.
REQ-007 busy  output  1  registered; high while a frame is in progress.
REQ-008 charSent  output  1  registered; one-cycle pulse on frame completion; same frame/timing contract as the receiver's charReceived input.

Function
REQ-009 The frame SHALL be 10 bits: start bit 0, then data bits parallelIn[7] down to parallelIn[0] (MSB first), then stop bit 1.
REQ-010 Each frame bit SHALL hold serialOut for exactly BIT_CYCLES clocks; total frame length is 10*BIT_CYCLES clocks.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP; transitions are IDLE->START on accepted load, START->DATA after one bit time, DATA->STOP after the 8th data bit time, and STOP->IDLE after one bit time.
REQ-012 A load SHALL be accepted only at a rising edge where busy is 0 and reset is 0; load while busy is 1 SHALL be ignored, not queued.
REQ-013 On acceptance at edge E0, parallelIn SHALL be captured into an internal shift register, and serialOut becomes 0 and busy becomes 1 after E0.
REQ-014 Changes on parallelIn after acceptance SHALL NOT affect the frame in progress.
REQ-015 The stop bit SHALL occupy the final BIT_CYCLES clocks, ending at edge E(10*BIT_CYCLES).
REQ-016 After edge E(10*BIT_CYCLES), busy SHALL be 0, serialOut 1, and charSent 1 for exactly one clock.
REQ-017 A load asserted during the charSent cycle SHALL be accepted at the next edge; minimum inter-frame gap is one idle clock at level 1.
REQ-018 In IDLE, serialOut SHALL be 1 and charSent 0 except in the REQ-016 cycle.
REQ-019 The bit timer SHALL count 0..BIT_CYCLES-1 and wrap; its width is clog2(BIT_CYCLES), minimum 1 bit.
REQ-020 The data-bit counter SHALL count 0..7 and SHALL NOT wrap within a frame.
REQ-021 With BIT_CYCLES=1, the timer SHALL produce a bit-advance every clock, with no idle insertion between bits.

Reset
REQ-022 When reset is 1 at an edge, after that edge: state IDLE, serialOut 1, busy 0, charSent 0, bit timer 0, data-bit counter 0.
REQ-023 Reset mid-frame SHALL abort the frame immediately and produce no charSent pulse.
REQ-024 Reset and load high at the same edge: reset wins and the load is dropped.
REQ-025 A load SHALL be accepted at the first edge with reset 0.

Structure
REQ-026 A shared package SHALL hold the state enum (IDLE, START, DATA, STOP) and the constants DATA_BITS=8, FRAME_BITS=10, START_LEVEL=0, STOP_LEVEL=1, IDLE_LEVEL=1, for reuse by s2p.
REQ-027 A bit-time divider sub-module bit_timer(clk, reset, enable, tick) parameterised by BIT_CYCLES SHALL produce the bit-advance tick; all other logic lives in p2s.

Verification
REQ-028 BIT_CYCLES=1, load 8'hA5 -> serialOut over 10 clocks = 0,1,0,1,0,0,1,0,1,1; busy high for 10 clocks; charSent pulses once in clock 11.
REQ-029 BIT_CYCLES=4, load 8'h01 -> each bit held 4 clocks (40 clocks total); last data bit 1; charSent pulses after clock 40.
REQ-030 Loopback: p2s serialOut->s2p serialIn, charSent->charReceived, BIT_CYCLES=1, frames 8'h3C then 8'hC3 back-to-back with load held high -> s2p parallelOut = 8'h3C, then 8'hC3; exactly one idle clock at 1 between frames.
REQ-031 Load 8'hFF, pulse load again at clock 3 with parallelIn=8'h00 -> second load ignored; frame carries 8'hFF unchanged; one charSent pulse total.
REQ-032 Load 8'h55, assert reset at clock 5 -> serialOut 1, busy 0 next clock; no charSent; a new load of 8'hAA next clock transmits a full correct frame.
REQ-033 Reset and load high at the same edge -> busy stays 0, serialOut stays 1.
